// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants for the ALU front-panel sequencer
package alu_seq_pkg;

   localparam int STATE_W    = 3;
   localparam int OP_LEN_DEF = 6;

   localparam logic [STATE_W-1:0] S_A    = 3'd0;
   localparam logic [STATE_W-1:0] S_B    = 3'd1;
   localparam logic [STATE_W-1:0] S_OP   = 3'd2;
   localparam logic [STATE_W-1:0] S_EXEC = 3'd3;
   localparam logic [STATE_W-1:0] S_SHOW = 3'd4;

   // Entry states echo the switches on the LEDs; the rest show the result.
   function automatic logic is_entry_state(input logic [STATE_W-1:0] st);
      return (st == S_A) || (st == S_B) || (st == S_OP);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, stability counter and press-edge pulse
module btn_debounce #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_press
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             level_dly_q, level_dly_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d     = i_raw;
      sync2_d     = sync1_q;
      level_d     = level_q;
      level_dly_d = level_q;
      press_d     = level_q & ~level_dly_q;
      cnt_d       = '0;
      // The counter only runs while the synced input disagrees with the accepted level.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         level_q     <= level_d;
         level_dly_q <= level_dly_d;
         press_q     <= press_d;
         cnt_q       <= cnt_d;
      end
   end

   assign o_level = level_q;
   assign o_press = press_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - guided A -> B -> OP -> EXEC -> SHOW entry FSM for the shared ALU
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int BUS_LEN    = 8,
   parameter int OP_LEN     = OP_LEN_DEF,
   parameter int DEB_CYCLES = 1000000,
   parameter int ALU_LAT    = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [BUS_LEN-1:0] i_sw,
   input  logic               i_btn_enter,
   input  logic               i_btn_back,
   output logic [BUS_LEN-1:0] o_ope1,
   output logic [BUS_LEN-1:0] o_ope2,
   output logic [OP_LEN-1:0]  o_opcode,
   output logic               o_start,
   input  logic [BUS_LEN-1:0] i_alu_result,
   output logic [BUS_LEN-1:0] o_led,
   output logic [2:0]         o_state,
   output logic               o_result_valid
);

   localparam int LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT);

   logic               enter_press;
   logic               back_press;

   logic [STATE_W-1:0] state_q, state_d;
   logic [BUS_LEN-1:0] ope1_q, ope1_d;
   logic [BUS_LEN-1:0] ope2_q, ope2_d;
   logic [OP_LEN-1:0]  opcode_q, opcode_d;
   logic [BUS_LEN-1:0] result_q, result_d;
   logic               valid_q, valid_d;
   logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (i_btn_enter),
      .o_level (),
      .o_press (enter_press)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_back (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (i_btn_back),
      .o_level (),
      .o_press (back_press)
   );

   always_comb begin
      state_d   = state_q;
      ope1_d    = ope1_q;
      ope2_d    = ope2_q;
      opcode_d  = opcode_q;
      result_d  = result_q;
      valid_d   = valid_q;
      lat_cnt_d = lat_cnt_q;
      o_start   = 1'b0;

      case (state_q)
         S_EXEC: begin
            // Buttons are deliberately ignored here so a result is always captured.
            o_start = (lat_cnt_q == '0);
            if (lat_cnt_q == LAT_LAST) begin
               result_d = i_alu_result;
               valid_d  = 1'b1;
               state_d  = S_SHOW;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         S_A, S_B, S_OP, S_SHOW: begin
            if (back_press) begin
               state_d = S_A;
               valid_d = 1'b0;
            end else if (enter_press) begin
               case (state_q)
                  S_A: begin
                     ope1_d  = i_sw;
                     state_d = S_B;
                  end
                  S_B: begin
                     ope2_d  = i_sw;
                     state_d = S_OP;
                  end
                  S_OP: begin
                     opcode_d  = i_sw[OP_LEN-1:0];
                     lat_cnt_d = '0;
                     state_d   = S_EXEC;
                  end
                  default: begin
                     valid_d = 1'b0;
                     state_d = S_A;
                  end
               endcase
            end
         end
         default: state_d = S_A;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_A;
         ope1_q    <= '0;
         ope2_q    <= '0;
         opcode_q  <= '0;
         result_q  <= '0;
         valid_q   <= 1'b0;
         lat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ope1_q    <= ope1_d;
         ope2_q    <= ope2_d;
         opcode_q  <= opcode_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

   assign o_ope1         = ope1_q;
   assign o_ope2         = ope2_q;
   assign o_opcode       = opcode_q;
   assign o_state        = state_q;
   assign o_result_valid = valid_q;
   // The previous result stays on the LEDs while a new operation executes.
   assign o_led          = is_entry_state(state_q) ? i_sw : result_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] i_sw = 8'hA5;
   logic       i_btn_enter = 1'b0;
   logic       i_btn_back = 1'b0;
   logic [7:0] o_ope1, o_ope2, o_led, i_alu_result;
   logic [5:0] o_opcode;
   logic       o_start, o_result_valid;
   logic [2:0] o_state;

   logic [21:0] start_q[$];
   logic [7:0]  result_q[$];
   int          checks = 0;
   int          failures = 0;
   int          press_cnt = 0;
   int          since_start = 100;
   logic        start_prev = 1'b0;
   logic        valid_prev = 1'b0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.BUS_LEN(8), .OP_LEN(6), .DEB_CYCLES(4), .ALU_LAT(1)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_sw           (i_sw),
      .i_btn_enter    (i_btn_enter),
      .i_btn_back     (i_btn_back),
      .o_ope1         (o_ope1),
      .o_ope2         (o_ope2),
      .o_opcode       (o_opcode),
      .o_start        (o_start),
      .i_alu_result   (i_alu_result),
      .o_led          (o_led),
      .o_state        (o_state),
      .o_result_valid (o_result_valid)
   );

   // One-cycle-latency ALU model.
   always @(posedge clk) begin
      if (o_opcode == OP_ADD)      i_alu_result <= o_ope1 + o_ope2;
      else if (o_opcode == OP_SUB) i_alu_result <= o_ope1 - o_ope2;
      else                         i_alu_result <= 8'h00;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (dut.enter_press) press_cnt++;
   end

   // Monitor: pops expectations whenever the DUT strobes start or raises result_valid.
   always @(negedge clk) begin
      since_start++;
      if (reset) begin
         start_prev = 1'b0;
         valid_prev = 1'b0;
      end else begin
         if (o_start) begin
            check("start_one_cycle", start_prev, 1'b0);
            check("start_expected", start_q.size() > 0, 1'b1);
            if (start_q.size() > 0) check("start_operands", {o_ope1, o_ope2, o_opcode}, start_q.pop_front());
            since_start = 0;
         end
         if (o_result_valid && !valid_prev) begin
            check("valid_latency", since_start, 2);
            check("result_expected", result_q.size() > 0, 1'b1);
            if (result_q.size() > 0) check("result_led", o_led, result_q.pop_front());
         end
         start_prev = o_start;
         valid_prev = o_result_valid;
      end
   end

   task automatic press_btn(input bit back, input logic [7:0] sw);
      i_sw = sw;
      if (back) i_btn_back = 1'b1; else i_btn_enter = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      i_btn_back = 1'b0;
      i_btn_enter = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic press_both(input logic [7:0] sw);
      i_sw = sw;
      i_btn_enter = 1'b1;
      i_btn_back = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      i_btn_enter = 1'b0;
      i_btn_back = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic wait_press(input string name, input int exp_k);
      int k = 0;
      bit seen = 1'b0;
      while (!seen && k < 20) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (dut.enter_press) seen = 1'b1;
      end
      check({name, "_seen"}, seen, 1'b1);
      if (seen) check({name, "_latency"}, k, exp_k);
   endtask

   initial begin
      int p0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", o_state, 3'd0);
      check("rst_ope1", o_ope1, 8'h00);
      check("rst_ope2", o_ope2, 8'h00);
      check("rst_opcode", o_opcode, 6'h00);
      check("rst_start", o_start, 1'b0);
      check("rst_valid", o_result_valid, 1'b0);
      check("rst_led", o_led, 8'hA5);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 05 + 03
      press_btn(1'b0, 8'h05);
      check("add_state_b", o_state, 3'd1);
      check("add_ope1", o_ope1, 8'h05);
      press_btn(1'b0, 8'h03);
      check("add_state_op", o_state, 3'd2);
      check("add_ope2", o_ope2, 8'h03);
      start_q.push_back({8'h05, 8'h03, 6'h20});
      result_q.push_back(8'h08);
      press_btn(1'b0, 8'h20);
      check("add_state_show", o_state, 3'd4);
      check("add_opcode", o_opcode, 6'h20);
      check("add_led", o_led, 8'h08);
      check("add_valid", o_result_valid, 1'b1);
      press_btn(1'b0, 8'h3C);
      check("show_exit_state", o_state, 3'd0);
      check("show_exit_valid", o_result_valid, 1'b0);
      check("show_exit_led", o_led, 8'h3C);

      // Bounce on Enter
      p0 = press_cnt;
      i_sw = 8'h11;
      for (int i = 0; i < 10; i++) begin
         i_btn_enter = ~i_btn_enter;
         repeat (2) @(posedge clk);
         #1;
      end
      check("bounce_no_press", press_cnt, p0);
      check("bounce_state", o_state, 3'd0);
      i_btn_enter = 1'b1;
      wait_press("bounce", 7);
      repeat (10) @(posedge clk);
      #1;
      check("bounce_one_press", press_cnt, p0 + 1);
      check("bounce_state_b", o_state, 3'd1);
      check("bounce_ope1", o_ope1, 8'h11);
      i_btn_enter = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Back from S_OP, then Enter+Back together in S_B
      press_btn(1'b0, 8'h22);
      check("back_pre_state", o_state, 3'd2);
      press_btn(1'b1, 8'h55);
      check("back_state", o_state, 3'd0);
      check("back_ope1", o_ope1, 8'h11);
      check("back_ope2", o_ope2, 8'h22);
      check("back_opcode", o_opcode, 6'h20);
      press_btn(1'b0, 8'h44);
      check("both_pre_state", o_state, 3'd1);
      press_both(8'h66);
      check("both_state", o_state, 3'd0);
      check("both_ope2", o_ope2, 8'h22);

      // Back pulse lands in the first EXEC cycle and must be ignored
      press_btn(1'b0, 8'h07);
      press_btn(1'b0, 8'h02);
      start_q.push_back({8'h07, 8'h02, OP_SUB});
      result_q.push_back(8'h05);
      i_sw = {2'b00, OP_SUB};
      i_btn_enter = 1'b1;
      @(posedge clk);
      #1;
      i_btn_back = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      check("lock_state", o_state, 3'd4);
      check("lock_valid", o_result_valid, 1'b1);
      check("lock_led", o_led, 8'h05);
      i_btn_enter = 1'b0;
      i_btn_back = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      press_btn(1'b0, 8'h99);
      check("lock_exit_state", o_state, 3'd0);
      check("lock_exit_valid", o_result_valid, 1'b0);
      check("lock_exit_led", o_led, 8'h99);

      // FF - 01 interrupted by reset in EXEC
      press_btn(1'b0, 8'hFF);
      press_btn(1'b0, 8'h01);
      i_sw = {2'b00, OP_SUB};
      i_btn_enter = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_state", o_state, 3'd0);
      check("mid_rst_start", o_start, 1'b0);
      check("mid_rst_ope1", o_ope1, 8'h00);
      check("mid_rst_ope2", o_ope2, 8'h00);
      check("mid_rst_opcode", o_opcode, 6'h00);
      check("mid_rst_valid", o_result_valid, 1'b0);
      check("mid_rst_led", o_led, 8'h22);
      repeat (3) @(posedge clk);
      #1;

      // Enter held across reset release
      p0 = press_cnt;
      reset = 1'b0;
      wait_press("hold", 7);
      check("hold_no_valid", o_result_valid, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      check("hold_one_press", press_cnt, p0 + 1);
      check("hold_state", o_state, 3'd1);
      check("hold_ope1", o_ope1, 8'h22);
      check("hold_no_valid_late", o_result_valid, 1'b0);
      i_btn_enter = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      check("start_queue_drained", start_q.size(), 0);
      check("result_queue_drained", result_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
